// File: rtl/mem_wb_reg_pkg.sv
// Shared CPU definitions for the MEM/WB boundary:
// load funct3 codes, write-back source codes and the stage bundle.
package mem_wb_reg_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [1:0] WD_PC4  = 2'd0;
  localparam logic [1:0] WD_ALU  = 2'd1;
  localparam logic [1:0] WD_MEM  = 2'd2;
  localparam logic [1:0] WD_ZERO = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_add4;
    logic [31:0] alu_res;
    logic [31:0] ld_data;
    logic [1:0]  wd_sel;
    logic        we;
    logic [4:0]  wa;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg_if.sv
// MEM -> WB bundle: the MEM side drives the master modport,
// the pipeline register sits on the slave modport.
interface mem_wb_reg_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic             flush;
  logic             mem_valid;
  logic [31:0]      mem_pc_add4;
  logic [31:0]      mem_alu_res;
  logic [31:0]      mem_dmem_rdata;
  logic [2:0]       mem_ld_type;
  logic [1:0]       mem_rf_wd_sel;
  logic             mem_rf_we;
  logic [4:0]       mem_rf_wa;
  logic             wb_valid;
  logic [31:0]      wb_pc_add4;
  logic [31:0]      wb_alu_res;
  logic [31:0]      wb_ld_data;
  logic [1:0]       wb_rf_wd_sel;
  logic [4:0]       wb_rf_wa;
  logic             wb_rf_we;
  logic [CNT_W-1:0] commit_cnt;

  modport master (
    output en, flush, mem_valid, mem_pc_add4,
    output mem_alu_res, mem_dmem_rdata, mem_ld_type,
    output mem_rf_wd_sel, mem_rf_we, mem_rf_wa,
    input  wb_valid, wb_pc_add4, wb_alu_res,
    input  wb_ld_data, wb_rf_wd_sel, wb_rf_wa,
    input  wb_rf_we, commit_cnt
  );

  modport slave (
    input  en, flush, mem_valid, mem_pc_add4,
    input  mem_alu_res, mem_dmem_rdata, mem_ld_type,
    input  mem_rf_wd_sel, mem_rf_we, mem_rf_wa,
    output wb_valid, wb_pc_add4, wb_alu_res,
    output wb_ld_data, wb_rf_wd_sel, wb_rf_wa,
    output wb_rf_we, commit_cnt
  );
endinterface

// File: rtl/mem_wb_reg_load_ext.sv
// Load data extraction: picks byte/half/word from an aligned
// memory word and sign- or zero-extends it.
module load_ext
  import mem_wb_reg_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword select ignores offset bit 0; misalignment never traps.
  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (type_i)
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data_o = {24'd0, byte_sel};
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with stall, flush, load extraction
// and a retired-instruction counter.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [31:0]      mem_pc_add4,
  input  logic [31:0]      mem_alu_res,
  input  logic [31:0]      mem_dmem_rdata,
  input  logic [2:0]       mem_ld_type,
  input  logic [1:0]       mem_rf_wd_sel,
  input  logic             mem_rf_we,
  input  logic [4:0]       mem_rf_wa,
  output logic             wb_valid,
  output logic [31:0]      wb_pc_add4,
  output logic [31:0]      wb_alu_res,
  output logic [31:0]      wb_ld_data,
  output logic [1:0]       wb_rf_wd_sel,
  output logic [4:0]       wb_rf_wa,
  output logic             wb_rf_we,
  output logic [CNT_W-1:0] commit_cnt
);

  mem_wb_t          st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ld_data;

  load_ext u_load_ext (
    .rdata_i  (mem_dmem_rdata),
    .offset_i (mem_alu_res[1:0]),
    .type_i   (mem_ld_type),
    .data_o   (ld_data)
  );

  // Flush beats stall; a flushed slot is a full bubble.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (flush) begin
      st_d = '0;
    end else if (en) begin
      st_d.valid   = mem_valid;
      st_d.pc_add4 = mem_pc_add4;
      st_d.alu_res = mem_alu_res;
      st_d.ld_data = ld_data;
      st_d.wd_sel  = mem_rf_wd_sel;
      st_d.we      = mem_rf_we;
      st_d.wa      = mem_rf_wa;
      cnt_d        = cnt_q + CNT_W'(mem_valid);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign wb_valid     = st_q.valid;
  assign wb_pc_add4   = st_q.pc_add4;
  assign wb_alu_res   = st_q.alu_res;
  assign wb_ld_data   = st_q.ld_data;
  assign wb_rf_wd_sel = st_q.wd_sel;
  assign wb_rf_wa     = st_q.wa;
  assign wb_rf_we     = st_q.we & st_q.valid & (|st_q.wa);
  assign commit_cnt   = cnt_q;

endmodule

// File: tb/tb_mem_wb_reg.sv
// Scoreboard bench for mem_wb_reg: directed vectors push
// expectations, a monitor pops and compares after each edge.
module tb_mem_wb_reg;
  import mem_wb_reg_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_wb_reg_if #(.CNT_W(32)) bus ();

  logic        w4_valid, w4_rf_we;
  logic [31:0] w4_pc, w4_alu, w4_ld;
  logic [1:0]  w4_sel;
  logic [4:0]  w4_wa;
  logic [3:0]  cnt4;

  mem_wb_reg #(.CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .en(bus.en), .flush(bus.flush),
    .mem_valid(bus.mem_valid), .mem_pc_add4(bus.mem_pc_add4),
    .mem_alu_res(bus.mem_alu_res),
    .mem_dmem_rdata(bus.mem_dmem_rdata),
    .mem_ld_type(bus.mem_ld_type),
    .mem_rf_wd_sel(bus.mem_rf_wd_sel),
    .mem_rf_we(bus.mem_rf_we), .mem_rf_wa(bus.mem_rf_wa),
    .wb_valid(bus.wb_valid), .wb_pc_add4(bus.wb_pc_add4),
    .wb_alu_res(bus.wb_alu_res), .wb_ld_data(bus.wb_ld_data),
    .wb_rf_wd_sel(bus.wb_rf_wd_sel), .wb_rf_wa(bus.wb_rf_wa),
    .wb_rf_we(bus.wb_rf_we), .commit_cnt(bus.commit_cnt)
  );

  mem_wb_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .en(bus.en), .flush(bus.flush),
    .mem_valid(bus.mem_valid), .mem_pc_add4(bus.mem_pc_add4),
    .mem_alu_res(bus.mem_alu_res),
    .mem_dmem_rdata(bus.mem_dmem_rdata),
    .mem_ld_type(bus.mem_ld_type),
    .mem_rf_wd_sel(bus.mem_rf_wd_sel),
    .mem_rf_we(bus.mem_rf_we), .mem_rf_wa(bus.mem_rf_wa),
    .wb_valid(w4_valid), .wb_pc_add4(w4_pc),
    .wb_alu_res(w4_alu), .wb_ld_data(w4_ld),
    .wb_rf_wd_sel(w4_sel), .wb_rf_wa(w4_wa),
    .wb_rf_we(w4_rf_we), .commit_cnt(cnt4)
  );

  typedef struct {
    int          id;
    logic        v;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [1:0]  sel;
    logic [4:0]  wa;
    logic        rfwe;
    logic [31:0] cnt;
    bit          data_ok;
  } exp_t;

  exp_t sbq[$];
  event chk_ev;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_id  = 0;

  // reference state
  logic        m_v, m_we;
  logic [31:0] m_pc, m_alu, m_ld, m_cnt;
  logic [1:0]  m_sel;
  logic [4:0]  m_wa;
  bit          m_data_ok;

  task automatic check(input int id, input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h",
               id, nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        check(e.id, "wb_valid", 32'(bus.wb_valid), 32'(e.v));
        check(e.id, "wb_rf_we", 32'(bus.wb_rf_we), 32'(e.rfwe));
        check(e.id, "wb_rf_wa", 32'(bus.wb_rf_wa), 32'(e.wa));
        check(e.id, "wb_rf_wd_sel", 32'(bus.wb_rf_wd_sel),
              32'(e.sel));
        check(e.id, "commit_cnt", bus.commit_cnt, e.cnt);
        check(e.id, "commit_cnt4", 32'(cnt4), 32'(e.cnt[3:0]));
        if (e.data_ok) begin
          check(e.id, "wb_pc_add4", bus.wb_pc_add4, e.pc);
          check(e.id, "wb_alu_res", bus.wb_alu_res, e.alu);
          check(e.id, "wb_ld_data", bus.wb_ld_data, e.ld);
        end
      end
    end
  end

  task automatic push_exp();
    exp_t e;
    e.id      = vec_id;
    e.v       = m_v;
    e.pc      = m_pc;
    e.alu     = m_alu;
    e.ld      = m_ld;
    e.sel     = m_sel;
    e.wa      = m_wa;
    e.rfwe    = m_we & m_v & (m_wa != 5'd0);
    e.cnt     = m_cnt;
    e.data_ok = m_data_ok;
    sbq.push_back(e);
    vec_id++;
  endtask

  task automatic model_reset();
    m_v = 0; m_we = 0; m_pc = 0; m_alu = 0; m_ld = 0;
    m_cnt = 0; m_sel = 0; m_wa = 0; m_data_ok = 1;
  endtask

  task automatic step(input logic e, input logic f,
                      input logic v, input logic [31:0] pc,
                      input logic [31:0] alu,
                      input logic [31:0] rd,
                      input logic [2:0] lt,
                      input logic [1:0] sel,
                      input logic we, input logic [4:0] wa,
                      input logic [31:0] exp_ld);
    @(negedge clk);
    bus.en             = e;
    bus.flush          = f;
    bus.mem_valid      = v;
    bus.mem_pc_add4    = pc;
    bus.mem_alu_res    = alu;
    bus.mem_dmem_rdata = rd;
    bus.mem_ld_type    = lt;
    bus.mem_rf_wd_sel  = sel;
    bus.mem_rf_we      = we;
    bus.mem_rf_wa      = wa;
    if (f) begin
      m_v = 0; m_we = 0; m_wa = 0; m_sel = 0;
      m_data_ok = 0;
    end else if (e) begin
      m_v = v; m_we = we; m_wa = wa; m_sel = sel;
      m_pc = pc; m_alu = alu; m_ld = exp_ld;
      m_data_ok = 1;
      if (v) m_cnt = m_cnt + 1;
    end
    push_exp();
    @(posedge clk);
  endtask

  // Reset between edges, checked before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    push_exp();
    -> chk_ev;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  localparam logic [31:0] RD = 32'h8070F0A5;

  initial begin
    bus.en = 0; bus.flush = 0; bus.mem_valid = 0;
    bus.mem_pc_add4 = 0; bus.mem_alu_res = 0;
    bus.mem_dmem_rdata = 0; bus.mem_ld_type = 0;
    bus.mem_rf_wd_sel = 0; bus.mem_rf_we = 0;
    bus.mem_rf_wa = 0;
    model_reset();
    #3;
    push_exp();
    -> chk_ev;
    @(negedge clk);
    rstn = 1'b1;

    step(1,0,1,32'h104,32'h1001,RD,LB, WD_MEM,1,5'd3,32'hFFFFFFF0);
    step(1,0,1,32'h108,32'h1003,RD,LBU,WD_MEM,1,5'd4,32'h00000080);
    step(1,0,1,32'h10C,32'h1002,RD,LH, WD_MEM,1,5'd5,32'hFFFF8070);
    step(1,0,1,32'h110,32'h1000,RD,LHU,WD_MEM,1,5'd6,32'h0000F0A5);
    step(1,0,1,32'h114,32'h1000,RD,LW, WD_MEM,1,5'd7,32'h8070F0A5);
    step(1,0,1,32'h118,32'h1003,RD,LH, WD_ALU,1,5'd8,32'hFFFF8070);
    step(1,0,1,32'h11C,32'h1000,RD,LB, WD_PC4,1,5'd9,32'hFFFFFFA5);
    step(1,0,1,32'h120,32'h1002,RD,LBU,WD_ZERO,1,5'd10,32'h00000070);
    step(1,0,1,32'h124,32'h1001,RD,LHU,WD_MEM,1,5'd11,32'h0000F0A5);
    step(1,0,1,32'h128,32'h1000,RD,3'b011,WD_MEM,0,5'd12,RD);

    step(0,0,1,32'h200,32'h0,32'h11111111,LW,WD_ALU,1,5'd1,32'h0);
    step(0,0,0,32'h204,32'h1,32'h22222222,LB,WD_PC4,1,5'd2,32'h0);
    step(0,0,1,32'h208,32'h2,32'h33333333,LH,WD_MEM,0,5'd3,32'h0);
    step(0,1,1,32'h20C,32'h3,32'h44444444,LW,WD_MEM,1,5'd4,32'h0);

    step(1,0,1,32'h300,32'h0,RD,LW,WD_ALU,1,5'd0,RD);
    step(1,0,0,32'h304,32'h0,RD,LW,WD_ALU,1,5'd5,RD);
    step(1,1,1,32'h308,32'h0,RD,LW,WD_ALU,1,5'd6,RD);

    step(0,0,1,32'h400,32'h0,RD,LW,WD_MEM,1,5'd7,RD);
    async_reset();
    step(1,0,1,32'h500,32'h0,RD,LW,WD_MEM,1,5'd1,RD);
    for (int i = 1; i < 17; i++) begin
      step(1,0,1,32'h500 + 32'(4*i),32'h0,32'(i),LW,WD_MEM,1,
           5'(i),32'(i));
    end

    @(negedge clk);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
               sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
